// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: state encoding,
// the bundle of pipeline-register controls and its canned values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MWAIT   = 2'd2
  } seq_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = pipe_ctl_t'(7'b1101010);
  localparam pipe_ctl_t CTL_FREEZE = pipe_ctl_t'(7'b0000001);
  localparam pipe_ctl_t CTL_ABORT  = pipe_ctl_t'(7'b0000011);
  localparam pipe_ctl_t CTL_RESET  = pipe_ctl_t'(7'b0010101);

endpackage

// File: rtl/pipe_sequencer_if.sv
// Decoder/hazard inputs, data-memory handshake and pipeline-control outputs
// of the sequencer. master = surrounding pipeline, slave = pipe_sequencer.
interface pipe_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt, ex_taken,
           mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, mem_timeout, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt, ex_taken,
           mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, mem_timeout, state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// $zero is never a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush/bubble sequencer for the 5-stage pipeline with data-memory
// wait handling and timeout. Define STALL_CNT_EN for stall/flush counters.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_sequencer_if.slave  bus
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              load_use;
  logic              flush_evt;
  pipe_ctl_t         ctl;

  load_use_detect u_load_use_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .load_use   (load_use)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal written here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    ctl       = CTL_RUN;
    flush_evt = 1'b0;
    if (rst) begin
      ctl = CTL_RESET;
    end else begin
      case (state_q)
        MWAIT: begin
          if (bus.mem_ready) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q == WAIT_MAX) begin
            // Give up on the access: push the stuck op out, bubble into WB.
            ctl       = CTL_ABORT;
            timeout_d = 1'b1;
            state_d   = RUN;
            wait_d    = '0;
          end else begin
            ctl    = CTL_FREEZE;
            wait_d = wait_q + WAIT_ONE;
          end
        end
        default: begin
          state_d = RUN;
          if (bus.mem_req && !bus.mem_ready) begin
            ctl     = CTL_FREEZE;
            state_d = MWAIT;
            wait_d  = WAIT_ONE;
          end else if (bus.ex_taken) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
            flush_evt      = 1'b1;
          end else if (load_use && (state_q == RUN)) begin
            // The load has already moved on by the LDSTALL cycle.
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
            state_d        = LDSTALL;
          end else if (bus.id_jump) begin
            ctl.ifid_flush = 1'b1;
            flush_evt      = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.pc_en        = ctl.pc_en;
  assign bus.ifid_en      = ctl.ifid_en;
  assign bus.ifid_flush   = ctl.ifid_flush;
  assign bus.idex_en      = ctl.idex_en;
  assign bus.idex_flush   = ctl.idex_flush;
  assign bus.exmem_en     = ctl.exmem_en;
  assign bus.memwb_bubble = ctl.memwb_bubble;
  assign bus.mem_timeout  = timeout_q;
  assign bus.state_o      = state_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Saturating: a wrapped counter would silently under-report.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctl.pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_flush_evt;
  assign unused_flush_evt = flush_evt;
  assign bus.stall_cnt    = '0;
  assign bus.flush_cnt    = '0;
`endif

endmodule
